mult_product_accumulator: RTL and testbench
===========================================

MULT_PRODUCT_ACCUMULATOR -- requirements
Module: mult_product_accumulator

Interface
REQ-001 Parameter ACC_W, default 16, accumulator and result width in bits (legal 8..32).
REQ-002 Parameter LEN, default 4, number of products summed per group (legal 2..256).
REQ-003 Parameter FIFO_DEPTH, default 4, input buffer entries (power of two, 2..16).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 prod_valid  input  1  prod carries a product from the 4-stage 4x4 multiplier this cycle.
REQ-007 prod  input  8  unsigned product, 0..225.
REQ-008 prod_ready  output  1  input buffer not full.
REQ-009 clear  input  1  synchronous flush of all group state.
REQ-010 acc_valid  output  1  acc_data holds a completed group sum.
REQ-011 acc_data  output  ACC_W  sum of LEN products.
REQ-012 acc_ready  input  1  downstream accepts acc_data.
REQ-013 acc_sat  output  1  completed sum was saturated (see REQ-027).
REQ-014 drop_err  output  1  sticky: a product arrived while the buffer was full.

Function
REQ-015 Product is written to the FIFO on a rising edge where prod_valid=1 and prod_ready=1.
REQ-016 prod_ready = (FIFO count < FIFO_DEPTH), registered-state based; no pop-to-push pass-through, so a push into a full buffer is rejected even when a pop occurs in the same cycle.
REQ-017 prod_valid=1 while prod_ready=0: product discarded, drop_err set to 1 and held until clear or rst.
REQ-018 FSM states: IDLE (cnt=0), ACC (0<cnt<LEN), OUT (result held).
REQ-019 In IDLE or ACC with FIFO non-empty: pop exactly one entry per cycle, sum <= sum + head, cnt <= cnt+1; IDLE->ACC on the first pop.
REQ-020 The pop that makes cnt=LEN latches acc_data, moves to OUT, asserts acc_valid, and resets sum/cnt to 0.
REQ-021 In OUT, no pops occur; FIFO keeps accepting until full; acc_data/acc_sat hold stable while acc_valid=1 and acc_ready=0.
REQ-022 OUT with acc_ready=1: acc_valid deasserts next cycle, state -> IDLE; next pop occurs the cycle after that.
REQ-023 Latency: with empty FIFO and state IDLE/ACC, the LEN-th product sampled in cycle c produces acc_valid=1 in cycle c+2.
REQ-024 Back-to-back throughput: one group every LEN+1 cycles with acc_ready held high.
REQ-025 clear=1 (priority over push, pop and handshake): FIFO emptied, sum/cnt=0, state IDLE, acc_valid=0, acc_sat=0, drop_err=0; the product presented that cycle is discarded without setting drop_err.

Reset
REQ-026 rst=1 asynchronously forces: state IDLE, FIFO empty, sum=0, cnt=0, acc_valid=0, acc_data=0, acc_sat=0, drop_err=0, prod_ready=0 while rst is high, 1 in the first cycle after release.

Configuration
REQ-027 Macro MULT_ACC_SAT_EN defined: running sum clamps at 2^ACC_W-1 and acc_sat=1 with that group's result; undefined: sum wraps modulo 2^ACC_W and acc_sat is tied to 0 (port always present).

Structure
REQ-028 Shared package mult_pkg holds PROD_W=8, MAX_PROD=225, and the FSM state typedef (IDLE, ACC, OUT).
REQ-029 FIFO is a sub-module mult_prod_fifo (push/pop/full/empty/count, synchronous flush, asynchronous reset); accumulator FSM lives in the top module.

Verification
REQ-030 Default params, products 10,20,30,40 on consecutive cycles, acc_ready=1 -> acc_valid one cycle, acc_data=100, in cycle after last product +2.
REQ-031 acc_ready=0 for 10 cycles after result, 8 further products streamed -> acc_data stable at result, prod_ready falls after 4 accepts, 5th push dropped, drop_err=1.
REQ-032 ACC_W=10, LEN=8, eight products of 225: with MULT_ACC_SAT_EN -> acc_data=1023, acc_sat=1; without -> acc_data=1800 mod 1024=776, acc_sat=0.
REQ-033 clear asserted after 2 of 4 products, then 4 products of 5 -> single result acc_data=20; drop_err=0.
REQ-034 rst pulsed mid-group and during OUT (asynchronously, off clock edge) -> all outputs zero immediately; next full group of 1,2,3,4 yields 10.
REQ-035 Random product stream with random acc_ready and a scoreboard of LEN-sums -> every accepted product counted exactly once, no result lost or duplicated.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the product accumulator: product width, product range
// and the accumulator FSM state encoding.
package mult_pkg;

  localparam int unsigned PROD_W   = 8;
  localparam int unsigned MAX_PROD = 225;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/mult_prod_fifo.sv
// Product input buffer: power-of-two circular FIFO with synchronous flush.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous empty (wins over push and pop)
//   push, din       write request and data (ignored when full)
//   pop, dout       read request (ignored when empty), head-of-queue data
//   full, empty     occupancy flags derived from the registered count
//   count           number of stored entries
module mult_prod_fifo
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = PROD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full & ~flush;
  assign rd_en = pop & ~empty & ~flush;
  assign dout  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  // Storage needs no reset; only entries behind valid pointers are read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mult_product_accumulator.sv
// Sums groups of LEN products arriving from a pipelined 4x4 multiplier and
// hands each group sum downstream over a valid/ready handshake.
// Build option: define MULT_ACC_SAT_EN to clamp the running sum at 2^ACC_W-1
// and flag the group through acc_sat; otherwise the sum wraps and acc_sat = 0.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   prod_valid, prod      incoming product, prod_ready = buffer not full
//   clear                 synchronous flush of buffer, group and flags
//   acc_valid, acc_data   completed group sum, held until acc_ready
//   acc_ready             downstream accept
//   acc_sat               completed sum was clamped
//   drop_err              sticky: a product arrived while the buffer was full
module mult_product_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned LEN        = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  input  logic              clear,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  input  logic              acc_ready,
  output logic              acc_sat,
  output logic              drop_err
);

  localparam int unsigned CNT_W  = $clog2(LEN);
  localparam int unsigned FC_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  acc_state_e        state, state_d;
  logic [ACC_W-1:0]  sum, sum_d, sum_add;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              run_sat, run_sat_d, sat_add;
  logic              acc_valid_d;
  logic [ACC_W-1:0]  acc_data_d;
  logic              acc_sat_d;
  logic              drop_err_d;

  logic              push;
  logic              pop;
  logic [PROD_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FC_W-1:0]   fifo_count;

  // No pop-to-push pass-through: readiness depends only on stored occupancy.
  assign prod_ready = ~rst & ~fifo_full;
  assign push       = prod_valid & prod_ready & ~clear;

  mult_prod_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PROD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (push),
    .din   (prod),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Running sum plus head of buffer; sat_add tracks clamping within the group.
`ifdef MULT_ACC_SAT_EN
  logic [ACC_W:0] sum_wide;
  always_comb begin
    sum_wide = {1'b0, sum} + (ACC_W + 1)'(fifo_head);
    sum_add  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    sat_add  = run_sat | sum_wide[ACC_W];
  end
`else
  always_comb begin
    sum_add = sum + ACC_W'(fifo_head);
    sat_add = run_sat;
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sum       <= '0;
      cnt       <= '0;
      run_sat   <= 1'b0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_sat   <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_d;
      sum       <= sum_d;
      cnt       <= cnt_d;
      run_sat   <= run_sat_d;
      acc_valid <= acc_valid_d;
      acc_data  <= acc_data_d;
      acc_sat   <= acc_sat_d;
      drop_err  <= drop_err_d;
    end
  end

  // Next-state and datapath updates; clear overrides everything.
  always_comb begin
    state_d     = state;
    sum_d       = sum;
    cnt_d       = cnt;
    run_sat_d   = run_sat;
    acc_valid_d = acc_valid;
    acc_data_d  = acc_data;
    acc_sat_d   = acc_sat;
    drop_err_d  = drop_err | (prod_valid & ~prod_ready);
    pop         = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      sum_d       = '0;
      cnt_d       = '0;
      run_sat_d   = 1'b0;
      acc_valid_d = 1'b0;
      acc_sat_d   = 1'b0;
      drop_err_d  = 1'b0;
    end else begin
      unique case (state)
        IDLE, ACC: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (cnt == LAST_CNT) begin
              acc_data_d  = sum_add;
              acc_sat_d   = sat_add;
              acc_valid_d = 1'b1;
              sum_d       = '0;
              cnt_d       = '0;
              run_sat_d   = 1'b0;
              state_d     = OUT;
            end else begin
              sum_d     = sum_add;
              cnt_d     = cnt + CNT_W'(1);
              run_sat_d = sat_add;
              state_d   = ACC;
            end
          end
        end
        OUT: begin
          if (acc_ready) begin
            acc_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Buffer occupancy can never exceed its depth; products stay in range.
  a_fifo_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= FC_W'(FIFO_DEPTH));
  a_prod_range: assert property (@(posedge clk) disable iff (rst)
    !prod_valid || (prod <= PROD_W'(MAX_PROD)));

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Self-checking bench for mult_product_accumulator: default-parameter instance
// for the functional scenarios, plus an ACC_W=10/LEN=8 instance for overflow.
module tb_mult_product_accumulator;

  localparam int unsigned ACC_W   = 16;
  localparam int unsigned LEN     = 4;
  localparam int unsigned B_ACC_W = 10;
  localparam int unsigned B_LEN   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             prod_valid = 1'b0;
  logic [7:0]       prod = '0;
  logic             acc_ready = 1'b0;
  logic             prod_ready, acc_valid, acc_sat, drop_err;
  logic [ACC_W-1:0] acc_data;

  logic               b_clear = 1'b0;
  logic               b_prod_valid = 1'b0;
  logic [7:0]         b_prod = '0;
  logic               b_acc_ready = 1'b1;
  logic               b_prod_ready, b_acc_valid, b_acc_sat, b_drop_err;
  logic [B_ACC_W-1:0] b_acc_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_product_accumulator #(.ACC_W(ACC_W), .LEN(LEN), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod),
    .prod_ready(prod_ready), .clear(clear), .acc_valid(acc_valid),
    .acc_data(acc_data), .acc_ready(acc_ready), .acc_sat(acc_sat),
    .drop_err(drop_err)
  );

  mult_product_accumulator #(.ACC_W(B_ACC_W), .LEN(B_LEN), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .prod_valid(b_prod_valid), .prod(b_prod),
    .prod_ready(b_prod_ready), .clear(b_clear), .acc_valid(b_acc_valid),
    .acc_data(b_acc_data), .acc_ready(b_acc_ready), .acc_sat(b_acc_sat),
    .drop_err(b_drop_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    prod_valid = 1'b0;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    tests++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL reset_acc_valid got %b exp 0", acc_valid); end
    tests++; if (acc_data !== '0) begin fails++; $display("FAIL reset_acc_data got %0d exp 0", acc_data); end
    tests++; if (acc_sat !== 1'b0) begin fails++; $display("FAIL reset_acc_sat got %b exp 0", acc_sat); end
    tests++; if (drop_err !== 1'b0) begin fails++; $display("FAIL reset_drop_err got %b exp 0", drop_err); end
    tests++; if (prod_ready !== 1'b0) begin fails++; $display("FAIL reset_prod_ready_high got %b exp 0", prod_ready); end
    rst = 1'b0;
    step();
    tests++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL reset_prod_ready_release got %b exp 1", prod_ready); end
    tests++; if (b_prod_ready !== 1'b1) begin fails++; $display("FAIL reset_b_prod_ready got %b exp 1", b_prod_ready); end
  endtask

  task automatic test_basic();
    int vals [4] = '{10, 20, 30, 40};
    pulse_clear();
    acc_ready = 1'b1;
    foreach (vals[i]) begin
      prod = 8'(vals[i]);
      prod_valid = 1'b1;
      step();
    end
    prod_valid = 1'b0;
    tests++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b exp 0", acc_valid); end
    step();
    tests++; if (acc_valid !== 1'b1) begin fails++; $display("FAIL basic_latency_valid got %b exp 1", acc_valid); end
    tests++; if (acc_data !== 16'd100) begin fails++; $display("FAIL basic_data got %0d exp 100", acc_data); end
    step();
    tests++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle got %b exp 0", acc_valid); end
  endtask

  task automatic test_backpressure();
    int waited;
    pulse_clear();
    acc_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      prod = 8'(i); prod_valid = 1'b1; step();
    end
    prod_valid = 1'b0;
    waited = 0;
    while (acc_valid !== 1'b1 && waited < 10) begin step(); waited++; end
    tests++; if (acc_data !== 16'd10) begin fails++; $display("FAIL bp_first_data got %0d exp 10", acc_data); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (prod_ready !== (i < 4)) begin fails++; $display("FAIL bp_ready_%0d got %b exp %b", i, prod_ready, (i < 4)); end
      prod = 8'(50 + i); prod_valid = 1'b1;
      step();
      tests++; if (acc_valid !== 1'b1 || acc_data !== 16'd10) begin fails++; $display("FAIL bp_hold_%0d got valid %b data %0d exp 1/10", i, acc_valid, acc_data); end
    end
    prod_valid = 1'b0;
    repeat (2) step();
    tests++; if (acc_valid !== 1'b1 || acc_data !== 16'd10) begin fails++; $display("FAIL bp_hold_end got valid %b data %0d exp 1/10", acc_valid, acc_data); end
    tests++; if (drop_err !== 1'b1) begin fails++; $display("FAIL bp_drop_err got %b exp 1", drop_err); end
    acc_ready = 1'b1;
    step();
    tests++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL bp_release got %b exp 0", acc_valid); end
    waited = 0;
    while (acc_valid !== 1'b1 && waited < 10) begin step(); waited++; end
    tests++; if (acc_valid !== 1'b1 || acc_data !== 16'd206) begin fails++; $display("FAIL bp_second_data got valid %b data %0d exp 1/206", acc_valid, acc_data); end
    tests++; if (drop_err !== 1'b1) begin fails++; $display("FAIL bp_drop_sticky got %b exp 1", drop_err); end
    step();
  endtask

  task automatic test_clear();
    int nres;
    logic [ACC_W-1:0] last;
    pulse_clear();
    tests++; if (drop_err !== 1'b0) begin fails++; $display("FAIL clr_drop_cleared got %b exp 0", drop_err); end
    acc_ready = 1'b1;
    prod_valid = 1'b1;
    prod = 8'd9;  step();
    prod = 8'd11; step();
    clear = 1'b1; prod = 8'd99; step();
    clear = 1'b0; prod_valid = 1'b0;
    tests++; if (drop_err !== 1'b0) begin fails++; $display("FAIL clr_no_drop got %b exp 0", drop_err); end
    for (int i = 0; i < 4; i++) begin
      prod = 8'd5; prod_valid = 1'b1; step();
    end
    prod_valid = 1'b0;
    nres = 0; last = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (acc_valid === 1'b1) begin nres++; last = acc_data; end
    end
    tests++; if (nres != 1 || last !== 16'd20) begin fails++; $display("FAIL clr_result got %0d results last %0d exp 1 result 20", nres, last); end
    tests++; if (drop_err !== 1'b0) begin fails++; $display("FAIL clr_drop_end got %b exp 0", drop_err); end
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    tests++; if (acc_valid !== 1'b0 || acc_data !== '0 || acc_sat !== 1'b0 || drop_err !== 1'b0 || prod_ready !== 1'b0) begin
      fails++; $display("FAIL arst_%s got valid %b data %0d sat %b drop %b ready %b exp all 0", tag, acc_valid, acc_data, acc_sat, drop_err, prod_ready);
    end
    #3 rst = 1'b0;
    step();
  endtask

  task automatic push_1234_and_wait(input logic ready, output logic got, output logic [ACC_W-1:0] data);
    int waited;
    acc_ready = ready;
    for (int i = 1; i <= 4; i++) begin
      prod = 8'(i); prod_valid = 1'b1; step();
    end
    prod_valid = 1'b0;
    waited = 0;
    while (acc_valid !== 1'b1 && waited < 10) begin step(); waited++; end
    got = acc_valid; data = acc_data;
  endtask

  task automatic test_async_reset();
    logic got;
    logic [ACC_W-1:0] data;
    pulse_clear();
    acc_ready = 1'b0;
    prod_valid = 1'b1;
    prod = 8'd7; step();
    prod = 8'd8; step();
    prod_valid = 1'b0;
    step();
    async_reset_pulse("mid_group");
    push_1234_and_wait(1'b0, got, data);
    tests++; if (got !== 1'b1 || data !== 16'd10) begin fails++; $display("FAIL arst_after_group got valid %b data %0d exp 1/10", got, data); end
    async_reset_pulse("in_out");
    push_1234_and_wait(1'b1, got, data);
    tests++; if (got !== 1'b1 || data !== 16'd10) begin fails++; $display("FAIL arst_after_out got valid %b data %0d exp 1/10", got, data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [ACC_W-1:0] exp_q [$];
    int rise [$];
    int gsum, gn, pushed;
    logic [ACC_W-1:0] e;
    pulse_clear();
    acc_ready = 1'b1;
    gsum = 0; gn = 0; pushed = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (acc_valid === 1'b1) begin
        rise.push_back(cyc);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        tests++; if (acc_data !== e) begin fails++; $display("FAIL b2b_data got %0d exp %0d", acc_data, e); end
      end
      if (pushed < 3 * LEN && prod_ready === 1'b1) begin
        prod = 8'($urandom_range(0, 225)); prod_valid = 1'b1;
        gsum += int'(prod); gn++; pushed++;
        if (gn == LEN) begin exp_q.push_back(ACC_W'(gsum)); gsum = 0; gn = 0; end
      end else begin
        prod_valid = 1'b0;
      end
      step();
    end
    prod_valid = 1'b0;
    tests++; if (rise.size() != 3) begin fails++; $display("FAIL b2b_count got %0d exp 3", rise.size()); end
    for (int i = 1; i < rise.size(); i++) begin
      tests++; if (rise[i] - rise[i-1] != LEN + 1) begin fails++; $display("FAIL b2b_interval got %0d exp %0d", rise[i] - rise[i-1], LEN + 1); end
    end
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] exp_q [$];
    int gsum, gn, nres, idle;
    logic [ACC_W-1:0] e;
    pulse_clear();
    gsum = 0; gn = 0; nres = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      acc_ready = ($urandom_range(0, 3) != 0);
      if (acc_valid === 1'b1 && acc_ready) begin
        nres++;
        if (exp_q.size() == 0) begin
          tests++; fails++; $display("FAIL rnd_extra_result got %0d exp none", acc_data);
        end else begin
          e = exp_q.pop_front();
          tests++; if (acc_data !== e || acc_sat !== 1'b0) begin fails++; $display("FAIL rnd_data got %0d sat %b exp %0d sat 0", acc_data, acc_sat, e); end
        end
      end
      if (prod_ready === 1'b1 && $urandom_range(0, 2) != 0) begin
        prod = 8'($urandom_range(0, 225)); prod_valid = 1'b1;
        gsum += int'(prod); gn++;
        if (gn == LEN) begin exp_q.push_back(ACC_W'(gsum)); gsum = 0; gn = 0; end
      end else begin
        prod_valid = 1'b0;
      end
      step();
    end
    prod_valid = 1'b0;
    acc_ready = 1'b1;
    idle = 0;
    while (exp_q.size() > 0 && idle < 100) begin
      if (acc_valid === 1'b1) begin
        e = exp_q.pop_front(); nres++;
        tests++; if (acc_data !== e) begin fails++; $display("FAIL rnd_drain_data got %0d exp %0d", acc_data, e); end
      end
      step(); idle++;
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rnd_lost_results got %0d pending exp 0", exp_q.size()); end
    repeat (8) begin
      tests++; if (acc_valid !== 1'b0) begin fails++; $display("FAIL rnd_duplicate got valid %b exp 0", acc_valid); end
      step();
    end
    tests++; if (drop_err !== 1'b0 || nres < 20) begin fails++; $display("FAIL rnd_summary got drop %b results %0d exp 0 and >=20", drop_err, nres); end
  endtask

  task automatic test_saturate();
    int waited;
    logic [B_ACC_W-1:0] exp_data;
    logic exp_sat;
`ifdef MULT_ACC_SAT_EN
    exp_data = 10'd1023; exp_sat = 1'b1;
`else
    exp_data = B_ACC_W'(1800 % 1024); exp_sat = 1'b0;
`endif
    b_acc_ready = 1'b1;
    waited = 0;
    for (int i = 0; i < B_LEN; i++) begin
      while (b_prod_ready !== 1'b1 && waited < 40) begin b_prod_valid = 1'b0; step(); waited++; end
      b_prod = 8'd225; b_prod_valid = 1'b1; step();
    end
    b_prod_valid = 1'b0;
    waited = 0;
    while (b_acc_valid !== 1'b1 && waited < 12) begin step(); waited++; end
    tests++; if (b_acc_valid !== 1'b1 || b_acc_data !== exp_data) begin fails++; $display("FAIL sat_data got valid %b data %0d exp 1/%0d", b_acc_valid, b_acc_data, exp_data); end
    tests++; if (b_acc_sat !== exp_sat) begin fails++; $display("FAIL sat_flag got %b exp %b", b_acc_sat, exp_sat); end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_back_to_back();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
